// File: rtl/instruction_feeder.sv
// Debounced push/step key front end feeding an 8-word instruction FIFO into the processor.
// Optional INSTR_FEEDER_REPLAY_EN adds a `replay` input that recirculates issued words.
module instruction_feeder #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_key,
    input  logic                       step_key,
`ifdef INSTR_FEEDER_REPLAY_EN
    input  logic                       replay,
`endif
    input  logic [WIDTH-1:0]           instruction_in,
    output logic [WIDTH-1:0]           instruction_out,
    output logic                       proc_step,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PUSH = 0;
    localparam int STEP = 1;

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       level_q, level_d;
    logic [1:0]       press_evt;
    logic [DW-1:0]    db_cnt_q [2];
    logic [DW-1:0]    db_cnt_d [2];
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    push_addr;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             do_pop;
    logic             replay_wr;
    logic             push_ok;

    // A key level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
            press_evt[i] = level_q[i] & ~level_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press_evt[STEP] && count_q != '0) state_d = LOAD;
            LOAD:    state_d = STROBE;
            STROBE:  state_d = RELEASE;
            RELEASE: if (level_q[STEP]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        proc_step = (state_q == STROBE);
    end

    // A pop frees a slot in the same cycle, so a push while full still fits unless replay refills it.
    always_comb begin
        do_pop = (state_q == LOAD);
`ifdef INSTR_FEEDER_REPLAY_EN
        replay_wr = do_pop & replay;
`else
        replay_wr = 1'b0;
`endif
        push_ok    = press_evt[PUSH] & ((count_q != CW'(DEPTH)) | (do_pop & ~replay_wr));
        push_addr  = wr_ptr_q + PW'(replay_wr);
        wr_ptr_d   = wr_ptr_q + PW'(replay_wr) + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        count_d    = count_q + CW'(push_ok) - CW'(do_pop & ~replay_wr);
        overflow_d = overflow_q | (press_evt[PUSH] & ~push_ok);
        instr_d    = do_pop ? mem[rd_ptr_q] : instr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            level_q    <= 2'b11;
            db_cnt_q   <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= {step_key, push_key};
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            instr_q    <= instr_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (replay_wr) mem[wr_ptr_q] <= mem[rd_ptr_q];
        if (push_ok)   mem[push_addr] <= instruction_in;
    end

    assign instruction_out = instr_q;
    assign count           = count_q;
    assign full            = (count_q == CW'(DEPTH));
    assign empty           = (count_q == '0);
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_instruction_feeder.sv
// Directed self-checking bench for instruction_feeder (replay checks only when
// INSTR_FEEDER_REPLAY_EN is defined).
module tb_instruction_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push_key = 1'b1;
    logic       step_key = 1'b1;
`ifdef INSTR_FEEDER_REPLAY_EN
    logic       replay = 1'b0;
`endif
    logic [7:0] instruction_in = 8'h00;
    logic [7:0] instruction_out;
    logic       proc_step;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    instruction_feeder dut (
        .clock           (clock),
        .reset           (reset),
        .push_key        (push_key),
        .step_key        (step_key),
`ifdef INSTR_FEEDER_REPLAY_EN
        .replay          (replay),
`endif
        .instruction_in  (instruction_in),
        .instruction_out (instruction_out),
        .proc_step       (proc_step),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Clean press and release of the push key with a stable switch value.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clock);
        instruction_in = value;
        push_key = 1'b0;
        waitCycles(8);
        push_key = 1'b1;
        waitCycles(8);
    endtask

    // Key driven low at a negedge: the debounced press event lands 6 edges later,
    // the load on the 7th edge, so proc_step is seen at the 7th negedge sample.
    task automatic stepAndCheck(input string tag, input logic [7:0] expected);
        int firstSeen = -1;
        int pulses = 0;
        logic [7:0] seenWord = 8'h00;
        @(negedge clock);
        step_key = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (proc_step) begin
                pulses++;
                if (firstSeen < 0) begin
                    firstSeen = k;
                    seenWord = instruction_out;
                end
            end
        end
        checkOutput({tag, "_latency"}, 32'(firstSeen), 32'd7);
        checkOutput({tag, "_word"}, 32'(seenWord), 32'(expected));
        checkOutput({tag, "_pulses"}, 32'(pulses), 32'd1);
        step_key = 1'b1;
        waitCycles(8);
    endtask

    initial begin
        int pulses;
        int waited;
        logic [7:0] heldWord;

        waitCycles(3);
        checkOutput("rst_out", 32'(instruction_out), 32'h0);
        checkOutput("rst_step", 32'(proc_step), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_full", 32'(full), 32'h0);
        checkOutput("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        waitCycles(2);

        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        checkOutput("t2_count", 32'(count), 32'd3);
        stepAndCheck("t2_s1", 8'h12);
        stepAndCheck("t2_s2", 8'h34);
        stepAndCheck("t2_s3", 8'h56);
        checkOutput("t2_empty", 32'(empty), 32'h1);

        // Bouncing push key, then a settled press: one word only.
        @(negedge clock);
        instruction_in = 8'h77;
        for (int i = 0; i < 10; i++) begin
            push_key = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clock);
        end
        push_key = 1'b0;
        waitCycles(8);
        push_key = 1'b1;
        waitCycles(8);
        checkOutput("t3_bounce_count", 32'(count), 32'd1);
        push_key = 1'b0;
        waitCycles(3);
        push_key = 1'b1;
        waitCycles(10);
        checkOutput("t3_short_count", 32'(count), 32'd1);
        stepAndCheck("t3_drain", 8'h77);

        for (int i = 0; i < 8; i++) applyStimulus(8'h80 + 8'(i));
        checkOutput("t4_fill_count", 32'(count), 32'd8);
        checkOutput("t4_fill_full", 32'(full), 32'h1);
        checkOutput("t4_fill_ovf", 32'(overflow), 32'h0);
        applyStimulus(8'hAA);
        checkOutput("t4_ovf", 32'(overflow), 32'h1);
        checkOutput("t4_ovf_count", 32'(count), 32'd8);
        checkOutput("t4_ovf_full", 32'(full), 32'h1);
        @(negedge clock);
        step_key = 1'b0;
        pulses = 0;
        heldWord = 8'h00;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (proc_step) begin
                pulses++;
                heldWord = instruction_out;
            end
        end
        checkOutput("t4_hold_pulses", 32'(pulses), 32'd1);
        checkOutput("t4_hold_word", 32'(heldWord), 32'h80);
        checkOutput("t4_hold_count", 32'(count), 32'd7);
        checkOutput("t4_hold_full", 32'(full), 32'h0);
        step_key = 1'b1;
        waitCycles(8);
        for (int i = 1; i < 8; i++) stepAndCheck("t4_drain", 8'h80 + 8'(i));
        checkOutput("t4_drained_count", 32'(count), 32'd0);
        checkOutput("t4_sticky_ovf", 32'(overflow), 32'h1);

        @(negedge clock);
        step_key = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (proc_step) pulses++;
        end
        checkOutput("t5_empty_pulses", 32'(pulses), 32'd0);
        checkOutput("t5_empty_word", 32'(instruction_out), 32'h87);
        step_key = 1'b1;
        waitCycles(8);
        @(negedge clock);
        instruction_in = 8'h5A;
        push_key = 1'b0;
        step_key = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (proc_step) pulses++;
        end
        checkOutput("t5_same_pulses", 32'(pulses), 32'd0);
        checkOutput("t5_same_count", 32'(count), 32'd1);
        push_key = 1'b1;
        step_key = 1'b1;
        waitCycles(8);
        stepAndCheck("t5_issue", 8'h5A);

        // Reset asserted while the strobe is high.
        applyStimulus(8'h3C);
        @(negedge clock);
        step_key = 1'b0;
        waited = 0;
        while (!proc_step && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("t1_reached_strobe", 32'(proc_step), 32'h1);
        checkOutput("t1_strobe_word", 32'(instruction_out), 32'h3C);
        reset = 1'b1;
        #1;
        checkOutput("t1_step", 32'(proc_step), 32'h0);
        checkOutput("t1_out", 32'(instruction_out), 32'h0);
        checkOutput("t1_count", 32'(count), 32'h0);
        checkOutput("t1_empty", 32'(empty), 32'h1);
        checkOutput("t1_ovf", 32'(overflow), 32'h0);
        step_key = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(3);

`ifdef INSTR_FEEDER_REPLAY_EN
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        replay = 1'b1;
        stepAndCheck("t6_r1", 8'h01);
        stepAndCheck("t6_r2", 8'h02);
        stepAndCheck("t6_r3", 8'h01);
        stepAndCheck("t6_r4", 8'h02);
        stepAndCheck("t6_r5", 8'h01);
        checkOutput("t6_count", 32'(count), 32'd2);
        replay = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
